noc_link_pipeline: RTL
======================

Name: noc_link_pipeline

Overview:
- Parametrised point-to-point link stage inserted between two mesh switch ports in place of the direct tile-to-tile wires.
- Carries the per-port valid, data and per-VC go bundle across a configurable number of register stages (Stages), so long mesh links close timing.
- Preserves stop-and-go flow control with a per-VC receive buffer that absorbs all in-flight flits.
- Adds a round-robin VC output arbiter and a sticky overflow flag for verification.

Parameters:
- NetworkDataWidth, 0: width of the compound link word (flit + type + broadcast + VC id).
- NetworkVirtualChannelIdWidth, 0: width of the VC id field, located in data bits [NetworkVirtualChannelIdWidth-1:0].
- NetworkNumberOfVirtualChannels, 0: number of VCs (per-VC go bits and buffers).
- Stages, 2: register stages in each direction. Allowed range 0..8.
- FifoDepth, 8: entries per VC buffer. Elaboration error if FifoDepth < 2*Stages+3.

Ports:
- clk_network_i  in  1  link clock; the only clock.
- rst_network_ni  in  1  asynchronous, active-low reset.
- network_valid_i  in  1  upstream flit valid.
- network_data_i  in  NetworkDataWidth  upstream flit; VC id in low bits.
- network_go_o  out  NetworkNumberOfVirtualChannels  per-VC go to upstream.
- network_valid_o  out  1  downstream flit valid.
- network_data_o  out  NetworkDataWidth  downstream flit.
- network_go_i  in  NetworkNumberOfVirtualChannels  per-VC go from downstream.
- overflow_o  out  1  sticky; set on a write to a full VC buffer.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All stage registers and FIFO pointers/counters clear.
  - network_valid_o=0, network_data_o=0, network_go_o=0, overflow_o=0.
  - Round-robin pointer=0.
- Forward path: valid/data pass through Stages registers. The last stage (or the inputs directly, when Stages=0) writes FIFO[vc], where vc = data[NetworkVirtualChannelIdWidth-1:0]. A vc value >= NetworkNumberOfVirtualChannels is dropped and sets overflow_o.
- Output:
  - Registered. Each cycle, select the next VC at or after rr_ptr with FIFO non-empty and network_go_i[vc]=1.
  - If one is found: pop it, load network_data_o, set network_valid_o=1, and set rr_ptr=vc+1 with wrap to 0 after NetworkNumberOfVirtualChannels-1.
  - Otherwise network_valid_o=0 and network_data_o holds its last value.
- Latency: valid_i at edge t gives valid_o high in cycle t+Stages+1 when the buffer is empty and go_i is high. Throughput is 1 flit/cycle.
- Simultaneous write and pop on the same VC: both occur, and occupancy is unchanged. A flit written at edge e is poppable from cycle e+1. There is no same-cycle bypass.
- Backward path:
  - Local go[vc] = (FifoDepth - count[vc]) >= 2*Stages+3, registered once.
  - It then passes through Stages registers to network_go_o.
  - go_o rises Stages+1 cycles after reset release.
  - Guard sizing guarantees no overflow for a compliant upstream, i.e. one that sends on vc only while it samples go_o[vc]=1.
- Ordering: flits are strictly FIFO within a VC. Interleaving across VCs follows round-robin.
- Full FIFO write: the flit is dropped, the FIFO is unchanged, and overflow_o=1 until reset.
- Empty FIFO: it is never selected. go_i transitions take effect in the same cycle's selection.
- Reset mid-stream: all in-flight and buffered flits are discarded. No partial output follows reset.
- Stages=0: the link reduces to buffer plus arbiter; the go guard is 3.

Test Plan:
- Latency check (Stages=2, 2 VCs, go_i=11): single flit 0x5A on VC0 at cycle 10 -> valid_o=1 with data 0x5A at cycle 13 only; go_o=11 throughout.
- Backpressure (Stages=2, FifoDepth=8): go_i[1]=0; upstream model streams 20 flits on VC1 while honouring go_o[1] -> go_o[1] falls once occupancy exceeds 1. After go_i[1]=1, all 20 flits emerge in order and overflow_o stays 0.
- Round-robin: preload 4 flits each on VC0 (A0..A3) and VC1 (B0..B3), then go_i=11 -> output A0,B0,A1,B1,A2,B2,A3,B3 on consecutive cycles.
- Overflow: force upstream to ignore go_o and push 12 flits to VC0 with go_i=0, FifoDepth=8 -> 8 stored, 4 dropped, overflow_o=1 from the first dropped write onward.
- Reset mid-stream: assert rst_network_ni with 5 flits buffered -> valid_o and go_o go to 0 immediately. After release: no stale flits, and go_o=all-ones after Stages+1 cycles.
- Stages=0 sweep: back-to-back flits alternating VC0/VC1 -> each appears one cycle later, in order, with no bubbles.

Source files
------------

// File: rtl/noc_link_pipeline.sv
// Pipelined mesh link stage: forward valid/data pipe into per-VC receive FIFOs,
// round-robin VC output arbiter, and a pipelined per-VC credit-style go return path.
module noc_link_pipeline #(
  parameter int NetworkDataWidth               = 8,
  parameter int NetworkVirtualChannelIdWidth   = 1,
  parameter int NetworkNumberOfVirtualChannels = 2,
  parameter int Stages                         = 2,
  parameter int FifoDepth                      = 8
) (
  input  logic                                      clk_network_i,
  input  logic                                      rst_network_ni,
  input  logic                                      network_valid_i,
  input  logic [NetworkDataWidth-1:0]               network_data_i,
  output logic [NetworkNumberOfVirtualChannels-1:0] network_go_o,
  output logic                                      network_valid_o,
  output logic [NetworkDataWidth-1:0]               network_data_o,
  input  logic [NetworkNumberOfVirtualChannels-1:0] network_go_i,
  output logic                                      overflow_o
);

  localparam int NumVc   = NetworkNumberOfVirtualChannels;
  localparam int DW      = NetworkDataWidth;
  localparam int VcIdW   = NetworkVirtualChannelIdWidth;
  localparam int Guard   = 2 * Stages + 3;
  localparam int PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW    = $clog2(FifoDepth + 1);
  localparam int VcSelW  = (NumVc > 1) ? $clog2(NumVc) : 1;

  if (Stages < 0 || Stages > 8) begin : g_bad_stages
    $error("noc_link_pipeline: Stages must be within 0..8");
  end
  if (FifoDepth < Guard) begin : g_bad_depth
    $error("noc_link_pipeline: FifoDepth must be at least 2*Stages+3");
  end

  logic          wr_valid;
  logic [DW-1:0] wr_data;

  // Forward pipe: the last stage (or the raw inputs) feeds the FIFO write port.
  if (Stages == 0) begin : g_fwd_bypass
    assign wr_valid = network_valid_i;
    assign wr_data  = network_data_i;
  end else begin : g_fwd_pipe
    logic [Stages-1:0]         v_q;
    logic [Stages-1:0][DW-1:0] d_q;

    always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
      if (!rst_network_ni) begin
        v_q <= '0;
        d_q <= '0;
      end else begin
        v_q[0] <= network_valid_i;
        d_q[0] <= network_data_i;
        for (int s = 1; s < Stages; s++) begin
          v_q[s] <= v_q[s-1];
          d_q[s] <= d_q[s-1];
        end
      end
    end

    assign wr_valid = v_q[Stages-1];
    assign wr_data  = d_q[Stages-1];
  end

  logic [DW-1:0]     mem    [NumVc][FifoDepth];
  logic [PtrW-1:0]   wr_ptr [NumVc];
  logic [PtrW-1:0]   rd_ptr [NumVc];
  logic [CntW-1:0]   count  [NumVc];
  logic [NumVc-1:0]  wr_en;
  logic [NumVc-1:0]  pop;
  logic              drop;
  logic [VcIdW-1:0]  wr_vc;
  logic [VcSelW-1:0] rr_ptr;
  logic [VcSelW-1:0] sel_vc;
  logic              sel_found;
  logic [NumVc-1:0]  go_local;

  assign wr_vc = wr_data[VcIdW-1:0];

  // Out-of-range VC ids and writes into a full buffer are both dropped.
  always_comb begin
    wr_en = '0;
    drop  = 1'b0;
    if (wr_valid) begin
      drop = 1'b1;
      for (int v = 0; v < NumVc; v++) begin
        if (int'(wr_vc) == v) begin
          if (count[v] != CntW'(FifoDepth)) begin
            wr_en[v] = 1'b1;
            drop     = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_vc    = '0;
    pop       = '0;
    for (int i = 0; i < NumVc; i++) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NumVc) idx = idx - NumVc;
      if (!sel_found && count[idx] != '0 && network_go_i[idx]) begin
        sel_found = 1'b1;
        sel_vc    = VcSelW'(idx);
      end
    end
    for (int v = 0; v < NumVc; v++) begin
      if (sel_found && int'(sel_vc) == v) pop[v] = 1'b1;
    end
  end

  always_ff @(posedge clk_network_i) begin
    for (int v = 0; v < NumVc; v++) begin
      if (wr_en[v]) mem[v][wr_ptr[v]] <= wr_data;
    end
  end

  always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
    if (!rst_network_ni) begin
      for (int v = 0; v < NumVc; v++) begin
        wr_ptr[v] <= '0;
        rd_ptr[v] <= '0;
        count[v]  <= '0;
      end
      go_local        <= '0;
      rr_ptr          <= '0;
      network_valid_o <= 1'b0;
      network_data_o  <= '0;
      overflow_o      <= 1'b0;
    end else begin
      for (int v = 0; v < NumVc; v++) begin
        if (wr_en[v]) begin
          wr_ptr[v] <= (wr_ptr[v] == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr[v] + PtrW'(1);
        end
        if (pop[v]) begin
          rd_ptr[v] <= (rd_ptr[v] == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr[v] + PtrW'(1);
        end
        case ({wr_en[v], pop[v]})
          2'b10:   count[v] <= count[v] + CntW'(1);
          2'b01:   count[v] <= count[v] - CntW'(1);
          default: count[v] <= count[v];
        endcase
        // Free space must cover every flit that can still be in flight once go drops.
        go_local[v] <= (FifoDepth - int'(count[v])) >= Guard;
      end

      if (sel_found) begin
        network_valid_o <= 1'b1;
        network_data_o  <= mem[sel_vc][rd_ptr[sel_vc]];
        rr_ptr          <= (int'(sel_vc) == NumVc - 1) ? '0 : sel_vc + VcSelW'(1);
      end else begin
        network_valid_o <= 1'b0;
      end

      if (drop) overflow_o <= 1'b1;
    end
  end

  // Backward pipe for the go bundle.
  if (Stages == 0) begin : g_bwd_bypass
    assign network_go_o = go_local;
  end else begin : g_bwd_pipe
    logic [Stages-1:0][NumVc-1:0] g_q;

    always_ff @(posedge clk_network_i or negedge rst_network_ni) begin
      if (!rst_network_ni) begin
        g_q <= '0;
      end else begin
        g_q[0] <= go_local;
        for (int s = 1; s < Stages; s++) begin
          g_q[s] <= g_q[s-1];
        end
      end
    end

    assign network_go_o = g_q[Stages-1];
  end

endmodule
